// File: rtl/alu_issue_stage.sv
// Decode-and-issue register for the logic ALU: turns and/or/xor/nor/andi/ori/xori/lui
// into ALU op codes and operands, and holds them in a single-entry valid/ready slot.
module alu_issue_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] inst,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [5:0]  out_op,
  output logic [4:0]  out_wa,
  output logic        out_we,
  output logic        out_illegal
);

  localparam logic [5:0] ALU_AND = 6'b010001;
  localparam logic [5:0] ALU_OR  = 6'b000100;
  localparam logic [5:0] ALU_XOR = 6'b000110;
  localparam logic [5:0] ALU_NOR = 6'b000101;
  localparam logic [5:0] ALU_LUI = 6'b001010;
  localparam logic [5:0] ALU_NOP = 6'b000000;

  logic [5:0]  opc_p0;
  logic [5:0]  funct_p0;
  logic [31:0] imm_p0;
  logic [31:0] a_p0;
  logic [31:0] b_p0;
  logic [5:0]  op_p0;
  logic [4:0]  wa_p0;
  logic        known_p0;
  logic        we_p0;
  logic        ill_p0;
  logic        load_p0;

  logic        vld_p1;
  logic [31:0] a_p1;
  logic [31:0] b_p1;
  logic [5:0]  op_p1;
  logic [4:0]  wa_p1;
  logic        we_p1;
  logic        ill_p1;

  assign opc_p0   = inst[31:26];
  assign funct_p0 = inst[5:0];
  assign imm_p0   = {16'h0000, inst[15:0]};

  // Stage p0: combinational decode of the incoming instruction
  always_comb begin
    a_p0     = '0;
    b_p0     = '0;
    op_p0    = ALU_NOP;
    wa_p0    = '0;
    known_p0 = 1'b0;
    if (opc_p0 == 6'b000000) begin
      known_p0 = 1'b1;
      a_p0     = rs_data;
      b_p0     = rt_data;
      wa_p0    = inst[15:11];
      unique case (funct_p0)
        6'b100100: op_p0 = ALU_AND;
        6'b100101: op_p0 = ALU_OR;
        6'b100110: op_p0 = ALU_XOR;
        6'b100111: op_p0 = ALU_NOR;
        default: begin
          known_p0 = 1'b0;
          a_p0     = '0;
          b_p0     = '0;
          wa_p0    = '0;
        end
      endcase
    end else begin
      known_p0 = 1'b1;
      a_p0     = rs_data;
      b_p0     = imm_p0;
      wa_p0    = inst[20:16];
      unique case (opc_p0)
        6'b001100: op_p0 = ALU_AND;
        6'b001101: op_p0 = ALU_OR;
        6'b001110: op_p0 = ALU_XOR;
        6'b001111: begin
          op_p0 = ALU_LUI;
          a_p0  = '0;
        end
        default: begin
          known_p0 = 1'b0;
          a_p0     = '0;
          b_p0     = '0;
          wa_p0    = '0;
        end
      endcase
    end
  end

  // An all-zero word is the canonical nop and must not raise an exception.
  assign we_p0   = known_p0 && (wa_p0 != 5'd0);
  assign ill_p0  = !known_p0 && (inst != 32'h0);
  assign in_ready = !vld_p1 || out_ready;
  assign load_p0  = in_valid && in_ready;

  // Stage p1: issue register toward EX
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      a_p1   <= '0;
      b_p1   <= '0;
      op_p1  <= ALU_NOP;
      wa_p1  <= '0;
      we_p1  <= 1'b0;
      ill_p1 <= 1'b0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (load_p0) begin
      vld_p1 <= 1'b1;
      a_p1   <= a_p0;
      b_p1   <= b_p0;
      op_p1  <= op_p0;
      wa_p1  <= wa_p0;
      we_p1  <= we_p0;
      ill_p1 <= ill_p0;
    end else if (out_ready && vld_p1) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_valid   = vld_p1;
  assign out_a       = a_p1;
  assign out_b       = b_p1;
  assign out_op      = op_p1;
  assign out_wa      = wa_p1;
  assign out_we      = we_p1;
  assign out_illegal = ill_p1;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed cases from the test plan, then
// randomized traffic with flush/reset/back-pressure checked against a reference decode.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] inst;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [5:0]  out_op;
  logic [4:0]  out_wa;
  logic        out_we;
  logic        out_illegal;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  op;
    logic [4:0]  wa;
    logic        we;
    logic        ill;
  } exp_t;

  exp_t sbq[$];

  alu_issue_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .rs_data(rs_data), .rt_data(rt_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .out_op(out_op), .out_wa(out_wa), .out_we(out_we), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  // Reference decode: logic ops indexed and/or/xor/nor, both for R-type funct 36..39
  // and for I-type opcodes 12..14; lui is opcode 15.
  function automatic exp_t model(input logic [31:0] w, input logic [31:0] rs, input logic [31:0] rt);
    logic [5:0] codes [4];
    exp_t e;
    int unsigned opc;
    int unsigned fn;
    bit rec;
    codes = '{6'b010001, 6'b000100, 6'b000110, 6'b000101};
    opc = int'(w[31:26]);
    fn  = int'(w[5:0]);
    e   = '0;
    rec = 1'b0;
    if (opc == 0 && fn >= 36 && fn <= 39) begin
      rec = 1'b1; e.op = codes[fn - 36]; e.a = rs; e.b = rt; e.wa = w[15:11];
    end else if (opc >= 12 && opc <= 14) begin
      rec = 1'b1; e.op = codes[opc - 12]; e.a = rs; e.b = 32'(w[15:0]); e.wa = w[20:16];
    end else if (opc == 15) begin
      rec = 1'b1; e.op = 6'b001010; e.a = 0; e.b = 32'(w[15:0]); e.wa = w[20:16];
    end
    e.we  = rec && (e.wa != 0);
    e.ill = !rec && (w != 0);
    return e;
  endfunction

  // Stimulus side of the scoreboard: record every accepted instruction.
  always @(posedge clk) begin
    if (rst) begin
      sbq.delete();
    end else if (flush) begin
      if (out_valid && !out_ready && sbq.size() > 0) void'(sbq.pop_back());
    end else if (in_valid && in_ready) begin
      sbq.push_back(model(inst, rs_data, rt_data));
    end
  end

  // Monitor: compare every EX-side transfer against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    exp_t act;
    if (!rst && out_valid && out_ready) begin
      checks++;
      act = '{out_a, out_b, out_op, out_wa, out_we, out_illegal};
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got a=%h b=%h op=%b wa=%0d we=%b ill=%b, required no transfer",
                 out_a, out_b, out_op, out_wa, out_we, out_illegal);
      end else begin
        e = sbq.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL sb_payload: got a=%h b=%h op=%b wa=%0d we=%b ill=%b, required a=%h b=%h op=%b wa=%0d we=%b ill=%b",
                   out_a, out_b, out_op, out_wa, out_we, out_illegal, e.a, e.b, e.op, e.wa, e.we, e.ill);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic issue(input logic [31:0] w, input logic [31:0] rs, input logic [31:0] rt);
    in_valid = 1'b1; inst = w; rs_data = rs; rt_data = rt;
    step();
    in_valid = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_a"}, out_a, 32'd0);
    chk({tag, "_b"}, out_b, 32'd0);
    chk({tag, "_op"}, 32'(out_op), 32'd0);
    chk({tag, "_wa"}, 32'(out_wa), 32'd0);
    chk({tag, "_we"}, 32'(out_we), 32'd0);
    chk({tag, "_ill"}, 32'(out_illegal), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 6))
      0: w = {6'd0, w[25:6], 6'(36 + $urandom_range(0, 3))};
      1: w = {6'(12 + $urandom_range(0, 3)), w[25:0]};
      2: w = 32'h0;
      3: w = {6'd0, w[25:16], 5'd0, w[10:6], 6'(36 + $urandom_range(0, 3))};
      4: w = {6'(12 + $urandom_range(0, 3)), w[25:21], 5'd0, w[15:0]};
      5: w = {6'd0, w[25:0]};
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; inst = '0; rs_data = '0; rt_data = '0;
    flush = 1'b0; out_ready = 1'b0;
    repeat (2) step();
    chk_reset_state("reset");
    rst = 1'b0;
    out_ready = 1'b1;

    issue(32'h00851824, 32'hF0F0F0F0, 32'h0FF00FF0);
    chk("and_valid", 32'(out_valid), 32'd1);
    chk("and_op", 32'(out_op), 32'h11);
    chk("and_a", out_a, 32'hF0F0F0F0);
    chk("and_b", out_b, 32'h0FF00FF0);
    chk("and_wa", 32'(out_wa), 32'd3);
    chk("and_we", 32'(out_we), 32'd1);

    issue(32'h3C0A1234, 32'hDEADBEEF, 32'h12345678);
    chk("lui_op", 32'(out_op), 32'h0A);
    chk("lui_a", out_a, 32'd0);
    chk("lui_b", out_b, 32'h00001234);
    chk("lui_wa", 32'(out_wa), 32'd10);
    chk("lui_we", 32'(out_we), 32'd1);

    issue(32'h3C0A8001, 32'hDEADBEEF, 32'h12345678);
    chk("lui_zext_b", out_b, 32'h00008001);

    issue(32'h3402FFFF, 32'h0, 32'hAAAAAAAA);
    chk("ori_op", 32'(out_op), 32'h04);
    chk("ori_b", out_b, 32'h0000FFFF);
    chk("ori_wa", 32'(out_wa), 32'd2);

    // xori $5,$4,0x5A5A held under back-pressure while an and waits upstream
    issue(32'h38855A5A, 32'h13579BDF, 32'h0);
    out_ready = 1'b0;
    in_valid = 1'b1; inst = 32'h00851824; rs_data = 32'h11112222; rt_data = 32'h33334444;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_op", 32'(out_op), 32'h06);
      chk("stall_a", out_a, 32'h13579BDF);
      chk("stall_b", out_b, 32'h00005A5A);
      chk("stall_wa", 32'(out_wa), 32'd5);
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("drain_load_valid", 32'(out_valid), 32'd1);
    chk("drain_load_op", 32'(out_op), 32'h11);
    chk("drain_load_a", out_a, 32'h11112222);

    issue(32'h8C020000, 32'h1, 32'h2);
    chk("lw_ill", 32'(out_illegal), 32'd1);
    chk("lw_we", 32'(out_we), 32'd0);
    chk("lw_op", 32'(out_op), 32'd0);

    issue(32'h00002024, 32'h0, 32'h0);
    chk("and_r4_wa", 32'(out_wa), 32'd4);
    chk("and_r4_we", 32'(out_we), 32'd1);

    issue(32'h00000024, 32'h0, 32'h0);
    chk("and_r0_we", 32'(out_we), 32'd0);
    chk("and_r0_ill", 32'(out_illegal), 32'd0);

    issue(32'h3402FFFF, 32'h0, 32'h0);
    out_ready = 1'b0;
    in_valid = 1'b1; flush = 1'b1; inst = 32'h00851824;
    step();
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_valid", 32'(out_valid), 32'd0);
    step();
    chk("flush_no_issue", 32'(out_valid), 32'd0);

    out_ready = 1'b1;
    issue(32'h3C0A1234, 32'h0, 32'h0);
    out_ready = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset_state("rst_stall");

    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      flush     = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      if (!(in_valid && !in_ready)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        inst     = rand_inst();
        rs_data  = $urandom;
        rt_data  = $urandom;
      end
      step();
    end

    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) step();
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    chk("final_valid", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Decode-and-issue pipeline register that feeds the 6-bit ALU op interface of the logic ALU (xor, nor, and, or, lui). It accepts fetched instructions plus register-file read data from the ID side and decodes opcode/funct into the ALU's op encoding. It selects the B operand (register or zero-extended immediate) and holds the result in a single-entry valid/ready register toward the EX stage. Stall, flush and illegal-instruction marking are handled here.

## Interface
- No parameters.
- `clk` input 1: rising-edge clock.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: `inst`/`rs_data`/`rt_data` valid this cycle.
- `in_ready` output 1: stage can accept; `in_ready = !out_valid || out_ready` (combinational).
- `inst` input 32: MIPS instruction word.
- `rs_data` input 32: register-file value of `inst[25:21]`.
- `rt_data` input 32: register-file value of `inst[20:16]`.
- `flush` input 1: discard held and incoming instruction.
- `out_valid` output 1: EX-side payload valid.
- `out_ready` input 1: EX accepts payload this cycle.
- `out_a` output 32: ALU operand a.
- `out_b` output 32: ALU operand b.
- `out_op` output 6: ALU op code.
- `out_wa` output 5: destination register.
- `out_we` output 1: register write enable.
- `out_illegal` output 1: instruction not supported by this datapath.

## Operation
- Decode (combinational from `inst`; op = `inst[31:26]`, funct = `inst[5:0]`):
  - R-type, op 000000:
    - funct 100100 (and): op 010001.
    - funct 100101 (or): op 000100.
    - funct 100110 (xor): op 000110.
    - funct 100111 (nor): op 000101.
    - For all four: a=`rs_data`, b=`rt_data`, wa=`inst[15:11]`, shamt ignored.
  - I-type:
    - andi 001100: op 010001.
    - ori 001101: op 000100.
    - xori 001110: op 000110.
    - For these three: a=`rs_data`, b={16'b0,`inst[15:0]`}, wa=`inst[20:16]`.
  - lui 001111: op 001010, a=0, b={16'b0,`inst[15:0]`}, wa=`inst[20:16]`. The ALU performs the shift.
  - `inst`==32'h0 (nop): op 000000, a=b=0, wa=0, we=0, illegal=0.
  - Anything else: op 000000, a=b=0, wa=0, we=0, illegal=1. The instruction still issues so the exception is taken downstream.
  - we=1 for every recognised instruction whose wa≠0. Writes to $0 are suppressed (we=0, illegal=0).
- Register update each clock, in priority order:
  1. `rst`: all outputs cleared.
  2. `flush`: `out_valid`←0. Payload is don't-care. The incoming instruction is dropped even if `in_valid`.
  3. `in_valid && in_ready`: load decoded payload, `out_valid`←1.
  4. `out_ready && out_valid` with no load: `out_valid`←0.
  5. Otherwise: hold all outputs unchanged (stall).
- While `out_valid && !out_ready`, the payload is stable and `in_ready`=0. Upstream must hold `inst` and data.
- No combinational path from `inst` to any `out_*` port. Only `in_ready` depends combinationally on `out_ready`.

## Timing
- Reset values:
  - `out_valid`=0, `out_a`=0, `out_b`=0, `out_op`=000000, `out_wa`=0, `out_we`=0, `out_illegal`=0.
  - `in_ready`=1 after reset.
- Latency is 1 cycle: an instruction accepted at edge N is visible on `out_*` after edge N.
- Throughput is 1 instruction/cycle while `out_ready`=1 (simultaneous drain and load at the same edge).
- `flush` asserted together with a handshake on either side:
  - The EX-side handshake that cycle still counts as a completed transfer.
  - The ID-side instruction is lost.
- `rst` mid-stall discards the held instruction. No partial state survives.

## Test plan
- Reset, then `in_valid`=1 with `inst`=32'h00851824 (and $3,$4,$5), `rs_data`=32'hF0F0F0F0, `rt_data`=32'h0FF00FF0, `out_ready`=1 -> next cycle:
  - `out_valid`=1, `out_op`=010001, `out_a`=F0F0F0F0, `out_b`=0FF00FF0, `out_wa`=3, `out_we`=1.
- `inst`=32'h3C0A1234 (lui $10,0x1234) -> `out_op`=001010, `out_a`=0, `out_b`=32'h00001234, `out_wa`=10, `out_we`=1.
- Same for `inst`=32'h3C0A8001 (lui $10,0x8001), checking zero extension -> `out_b`=32'h00008001.
- `inst`=32'h3402FFFF (ori $2,$0,0xFFFF) -> `out_op`=000100, `out_b`=32'h0000FFFF (no sign extension), `out_wa`=2.
- Stall: load xori, then hold `out_ready`=0 for 3 cycles while presenting a new instruction:
  - `in_ready`=0 and the payload is unchanged all 3 cycles.
  - Raise `out_ready` -> transfer completes, the new instruction loads on the same edge, and `out_valid` stays 1.
- `inst`=32'h8C020000 (lw, unsupported) -> `out_illegal`=1, `out_we`=0, `out_op`=000000.
- `inst`=32'h00002024 (and $4,$0,$0), wa=4 -> `out_we`=1.
- `inst`=32'h00000024 (and $0,$0,$0) -> `out_we`=0, `out_illegal`=0.
- `flush` and `in_valid` together while `out_valid`=1, `out_ready`=0 -> next cycle `out_valid`=0 and no instruction issues.
- Assert `rst` during a stall -> all outputs at reset values next cycle.
